// File: rtl/spimem_pkg.sv
// rtl/spimem_pkg.sv - shared constants, width helpers and FSM states for the SPI-memory read cache
//   LINE_WORDS : 32-bit words per cache line
//   ADDR_W     : CPU and flash byte-address width
//   OFFS_W     : byte-offset bits inside one line
//   state_e    : controller states IDLE / FILL / RESP
package spimem_pkg;

  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 24;
  localparam int OFFS_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return ADDR_W - OFFS_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/spimem_cache_ram.sv
// rtl/spimem_cache_ram.sv - line data array, one synchronous write port and one asynchronous read port
//   clk   : write clock
//   we    : write enable
//   waddr : write word address {index, word}
//   wdata : write data
//   raddr : read word address {index, word}
//   rdata : read data, combinational from raddr
module spimem_cache_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read lets a hit be answered one edge after the request.
  assign rdata = mem[raddr];

endmodule

// File: rtl/spimem_cache.sv
// rtl/spimem_cache.sv - direct-mapped read cache in front of a SPI flash controller
//   clk, resetn          : clock, asynchronous active-low reset
//   valid/ready          : CPU read request (held) / one-cycle response strobe
//   addr/rdata           : CPU byte address / read data while ready=1
//   flush                : invalidate all lines
//   mem_valid/mem_ready  : flash word request / flash word-done strobe
//   mem_addr/mem_rdata   : flash word address / flash word data
module spimem_cache
  import spimem_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       rdata,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int IDX_W  = idx_width(LINES);
  localparam int TAG_W  = tag_width(LINES);
  localparam int RAM_AW = IDX_W + 2;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [1:0]         fill_cnt_q, fill_cnt_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [1:0]         req_word_q, req_word_d;
  logic               poison_q, poison_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]   tag_q [LINES];
  logic               tag_we;

  logic [1:0]         cpu_word;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               hit;
  logic               word_done;
  logic               unused_addr_bits;

  logic               ram_we;
  logic [RAM_AW-1:0]  ram_waddr;
  logic [RAM_AW-1:0]  ram_raddr;
  logic [31:0]        ram_rdata;

  assign cpu_word = addr[3:2];
  assign cpu_idx  = addr[OFFS_W +: IDX_W];
  assign cpu_tag  = addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^addr[1:0];

  // A flush in the same cycle as a hit forces the miss path.
  assign hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag) && !flush;

  // mem_ready only counts while a request is actually outstanding.
  assign word_done = (state_q == FILL) && mem_valid_q && mem_ready;

  assign ram_we    = word_done;
  assign ram_waddr = {req_idx_q, fill_cnt_q};
  assign ram_raddr = (state_q == IDLE) ? {cpu_idx, cpu_word} : {req_idx_q, req_word_q};

  spimem_cache_ram #(
    .DEPTH (LINES * LINE_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (mem_rdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    fill_cnt_d  = fill_cnt_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_word_d  = req_word_q;
    poison_d    = poison_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    tag_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (hit) begin
            rdata_d = ram_rdata;
            ready_d = 1'b1;
            state_d = RESP;
          end else begin
            // The line is about to be overwritten word by word, so it must
            // not be visible until the fill has fully landed.
            valid_d[cpu_idx] = 1'b0;
            fill_cnt_d  = 2'd0;
            req_tag_d   = cpu_tag;
            req_idx_d   = cpu_idx;
            req_word_d  = cpu_word;
            poison_d    = flush;
            mem_valid_d = 1'b1;
            mem_addr_d  = {cpu_tag, cpu_idx, 2'b00, 2'b00};
            state_d     = FILL;
          end
        end
      end

      FILL: begin
        if (flush) begin
          poison_d = 1'b1;
        end
        if (mem_valid_q) begin
          if (mem_ready) begin
            // Drop the request for one cycle so each word is a new request.
            mem_valid_d = 1'b0;
            fill_cnt_d  = fill_cnt_q + 2'd1;
            if (fill_cnt_q == 2'd3) begin
              if (!poison_q && !flush) begin
                tag_we = 1'b1;
                valid_d[req_idx_q] = 1'b1;
              end
              // Word 3 is being written this edge, so take it straight from the bus.
              rdata_d = (req_word_q == 2'd3) ? mem_rdata : ram_rdata;
              if (valid) begin
                ready_d = 1'b1;
                state_d = RESP;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = {req_tag_q, req_idx_q, fill_cnt_q, 2'b00};
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      fill_cnt_q  <= 2'd0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= 2'd0;
      poison_q    <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      fill_cnt_q  <= fill_cnt_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_word_q  <= req_word_d;
      poison_q    <= poison_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[req_idx_q] <= req_tag_q;
    end
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_spimem_cache.sv
// tb/tb_spimem_cache.sv - directed table-driven bench for spimem_cache with a flash responder model
module tb_spimem_cache;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [23:0] addr;
  logic [31:0] rdata;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  int tests_run;
  int tests_failed;
  int proto_err;
  int ready_viol;
  int ready_pulses;
  bit mem_stall;
  logic [23:0] fill_log [$];

  spimem_cache #(.LINES(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .ready     (ready),
    .addr      (addr),
    .rdata     (rdata),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash model and protocol monitor, evaluated on the falling edge.
  // Each word request is answered in the same cycle it appears, data = address.
  initial begin
    logic        prev_mv;
    logic [23:0] prev_ma;
    prev_mv   = 1'b0;
    prev_ma   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ready && !valid) ready_viol++;
      if (ready) ready_pulses++;
      if (resetn && prev_mv) begin
        if (!mem_ready && (!mem_valid || mem_addr != prev_ma)) proto_err++;
        if (mem_ready && mem_valid) proto_err++;
      end
      prev_mv = resetn && mem_valid;
      prev_ma = mem_addr;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (resetn && mem_valid && !mem_stall) begin
        mem_ready = 1'b1;
        mem_rdata = {8'h00, mem_addr};
        fill_log.push_back(mem_addr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input string name, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (ready) ok = 1'b1;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got no ready expected ready within 200 cycles", name);
    end
  endtask

  // Finishes one cycle after ready, with valid released and ready re-checked low.
  task automatic finish_resp(input string name, output logic [31:0] d);
    d = rdata;
    @(posedge clk); #1;
    valid = 1'b0;
    check({name, "_ready_one_cycle"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic do_read(input string name, input logic [23:0] a, input logic [31:0] exp_d,
                         input int exp_fills, input logic [23:0] exp_first);
    int          lat;
    bit          ok;
    logic [31:0] d;
    logic [23:0] fa;
    fill_log.delete();
    addr  = a;
    valid = 1'b1;
    wait_resp(name, lat, ok);
    if (ok) begin
      finish_resp(name, d);
      check({name, "_rdata"}, d, exp_d);
      check({name, "_latency"}, lat, (exp_fills != 0) ? 32'd8 : 32'd1);
      check({name, "_fills"}, fill_log.size(), exp_fills);
      for (int k = 0; k < exp_fills && k < fill_log.size(); k++) begin
        fa = exp_first + 24'(4 * k);
        check({name, "_fill_addr"}, {8'h00, fill_log[k]}, {8'h00, fa});
      end
    end else begin
      valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [23:0] a;
    logic [31:0] d;
    int          fills;
    logic [23:0] first;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          n;
    int          lat;
    int          r0;
    bit          ok;
    logic [31:0] d;

    vecs[0]  = '{24'h000104, 32'h00000104, 4, 24'h000100};
    vecs[1]  = '{24'h00010C, 32'h0000010C, 0, 24'h000000};
    vecs[2]  = '{24'h000100, 32'h00000100, 0, 24'h000000};
    vecs[3]  = '{24'h000904, 32'h00000904, 4, 24'h000900};
    vecs[4]  = '{24'h000104, 32'h00000104, 4, 24'h000100};
    vecs[5]  = '{24'h000114, 32'h00000114, 4, 24'h000110};
    vecs[6]  = '{24'h000118, 32'h00000118, 0, 24'h000000};
    vecs[7]  = '{24'h00090C, 32'h0000090C, 4, 24'h000900};
    vecs[8]  = '{24'hFFFFFC, 32'h00FFFFFC, 4, 24'hFFFFF0};
    vecs[9]  = '{24'hFFFFF0, 32'h00FFFFF0, 0, 24'h000000};
    vecs[10] = '{24'h000107, 32'h00000104, 4, 24'h000100};
    vecs[11] = '{24'h000103, 32'h00000100, 0, 24'h000000};

    tests_run    = 0;
    tests_failed = 0;
    proto_err    = 0;
    ready_viol   = 0;
    ready_pulses = 0;
    mem_stall    = 1'b0;
    resetn       = 1'b0;
    valid        = 1'b0;
    addr         = '0;
    flush        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("reset_mem_addr", {8'h00, mem_addr}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].d, vecs[i].fills, vecs[i].first);
    end

    // Flush pulsed during the second word of a fill: data still returned, line not kept.
    fill_log.delete();
    addr  = 24'h000200;
    valid = 1'b1;
    n = 0;
    while (fill_log.size() < 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("flush_first_word_seen", fill_log.size(), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_resp("flush_fill", lat, ok);
    if (ok) begin
      finish_resp("flush_fill", d);
      check("flush_fill_rdata", d, 32'h00000200);
      check("flush_fill_words", fill_log.size(), 32'd4);
    end else begin
      valid = 1'b0;
    end
    do_read("flush_reread", 24'h000200, 32'h00000200, 4, 24'h000200);
    do_read("flush_other_line", 24'h000118, 32'h00000118, 4, 24'h000110);

    // Reset while a word request is outstanding.
    mem_stall = 1'b1;
    fill_log.delete();
    addr  = 24'h000304;
    valid = 1'b1;
    n = 0;
    while (!mem_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_fill_mem_valid", {31'd0, mem_valid}, 32'd1);
    check("rst_fill_mem_addr", {8'h00, mem_addr}, 32'h00000300);
    r0 = ready_pulses;
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_async_ready", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    @(posedge clk); #1;
    resetn    = 1'b1;
    mem_stall = 1'b0;
    @(posedge clk); #1;
    check("rst_no_ready", ready_pulses - r0, 32'd0);
    do_read("rst_after_0x10c", 24'h00010C, 32'h0000010C, 4, 24'h000100);
    do_read("rst_refill_0x300", 24'h000300, 32'h00000300, 4, 24'h000300);

    // CPU abandons the request after the first word; fill still installs the line.
    fill_log.delete();
    addr  = 24'h000400;
    valid = 1'b1;
    n = 0;
    while (fill_log.size() < 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0;
    r0 = ready_pulses;
    n = 0;
    while (fill_log.size() < 4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drop_fill_words", fill_log.size(), 32'd4);
    check("drop_no_ready", ready_pulses - r0, 32'd0);
    check("drop_mem_valid_idle", {31'd0, mem_valid}, 32'd0);
    do_read("drop_hit_0x408", 24'h000408, 32'h00000408, 0, 24'h000000);

    check("mem_handshake_protocol", proto_err, 32'd0);
    check("ready_without_valid", ready_viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spimem_cache.md
SPIMEM_CACHE -- requirements
Module: spimem_cache

Interface
REQ-001 SHALL have parameter LINES, default 8, number of direct-mapped lines (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid  input  1  CPU read request, held until ready.
REQ-005 SHALL have port ready  output  1  single-cycle response strobe to CPU.
REQ-006 SHALL have port addr  input  24  CPU byte address; bits [1:0] ignored.
REQ-007 SHALL have port rdata  output  32  read data, valid while ready=1.
REQ-008 SHALL have port flush  input  1  invalidate all lines; pulse or level.
REQ-009 SHALL have port mem_valid  output  1  request to the flash controller.
REQ-010 SHALL have port mem_ready  input  1  flash controller word-done strobe.
REQ-011 SHALL have port mem_addr  output  24  flash word address, [1:0]=0.
REQ-012 SHALL have port mem_rdata  input  32  flash word, sampled when mem_ready=1.

Function
REQ-013 Line = 4 words (16 B); word = addr[3:2], index = addr[4+log2(LINES)-1:4], tag = remaining upper bits; per line one valid bit and one tag.
REQ-014 FSM states SHALL be IDLE, FILL, RESP.
REQ-015 IDLE: on valid=1 with valid bit set, tag match and flush=0 (hit), SHALL load rdata from array and go RESP; otherwise (miss) SHALL clear that line's valid bit, set fill_cnt=0, go FILL.
REQ-016 FILL: mem_valid=1, mem_addr={tag,index,fill_cnt,2'b00}; mem_valid and mem_addr SHALL stay stable until mem_ready=1.
REQ-017 FILL: on mem_ready=1 SHALL write mem_rdata into word fill_cnt and increment fill_cnt; mem_valid SHALL be 0 the cycle after mem_ready so each word is a distinct request.
REQ-018 Fill order SHALL be word 0,1,2,3 (sequential addresses, no carry out of the line), independent of requested word.
REQ-019 On the 4th mem_ready SHALL set tag and valid bit (unless REQ-022 applies), load rdata with the requested word (bypass from mem_rdata if word 3), go RESP if valid=1, else IDLE.
REQ-020 RESP: ready=1 for exactly one cycle, then IDLE; no lookup is started in the RESP cycle.
REQ-021 Hit latency SHALL be 1 cycle (valid at edge N, ready high during cycle N+1); miss latency = fill time + 1 cycle.
REQ-022 flush=1 SHALL clear all valid bits at the next edge; flush during FILL SHALL let the fill complete and return data but SHALL NOT set the line valid.
REQ-023 Simultaneous flush and hit in IDLE SHALL be treated as a miss.
REQ-024 valid dropping during FILL SHALL NOT abort the fill; line is installed, no ready pulse.
REQ-025 ready SHALL never be asserted while valid=0.

Reset
REQ-026 resetn=0 SHALL asynchronously force state=IDLE, all valid bits=0, fill_cnt=0, ready=0, mem_valid=0, mem_addr=0, rdata=0.
REQ-027 Reset mid-fill SHALL drop mem_valid immediately; the partial line remains invalid.
REQ-028 Data array and tag storage SHALL NOT require reset.

Structure
REQ-029 A shared package spimem_pkg SHALL hold LINE_WORDS=4, ADDR_W=24, the index/tag width functions, and the FSM state enumeration.
REQ-030 One sub-module spimem_cache_ram (LINES*4 x 32, one synchronous write port, one read port) SHALL hold the data array; tags and valid bits stay in registers in spimem_cache.

Verification
REQ-031 Reset, read 0x000104 with mem model returning word=addr -> mem_addr sequence 0x100,0x104,0x108,0x10C, then ready with rdata=0x00000104.
REQ-032 After REQ-031, read 0x00010C -> ready one cycle after valid, rdata=0x0000010C, mem_valid stays 0.
REQ-033 Read 0x000904 (same index, new tag, LINES=8) -> full refill at 0x900..0x90C, rdata=0x00000904; re-read 0x000104 misses again.
REQ-034 Pulse flush during 2nd word of a fill of 0x000200 -> ready with rdata=0x00000200, then re-read 0x000200 triggers a new 4-word fill.
REQ-035 Assert resetn=0 while mem_valid=1 at 0x000304 -> mem_valid=0 same cycle, no ready; after release, read 0x000300 refills from 0x300.
REQ-036 Drop valid after first mem_ready of fill 0x000400 -> fill completes, no ready; then read 0x000408 hits with 1-cycle latency, rdata=0x00000408.
